// File: rtl/ofm_pkg.sv
// ofm_pkg: shared widths, pixel-set type, FSM states and the word packing helper
// for the OFM write-back path.
package ofm_pkg;

    localparam int NUM_PE        = 16;
    localparam int DATA_W        = 8;
    localparam int WORD_W        = 32;
    localparam int ADDR_W        = 20;
    localparam int WORDS_PER_SET = NUM_PE * DATA_W / WORD_W;
    localparam int EPW           = WORD_W / DATA_W;
    localparam int PE_W          = $clog2(NUM_PE);
    localparam int WIDX_W        = WORDS_PER_SET > 1 ? $clog2(WORDS_PER_SET) : 1;

    typedef logic [NUM_PE-1:0][DATA_W-1:0] pixel_set_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } wb_state_e;

    // Word k holds PE EPW*k in its top byte, followed by the next PEs in descending bit order.
    function automatic logic [WORD_W-1:0] pack_word(pixel_set_t s, logic [WIDX_W-1:0] k);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int i = 0; i < EPW; i++)
            w = {w[WORD_W-DATA_W-1:0], s[PE_W'(int'(k) * EPW + i)]};
        return w;
    endfunction

endpackage

// File: rtl/ofm_set_fifo.sv
// ofm_set_fifo: small circular buffer of pixel sets between capture and the word serializer.
// The caller only pushes when a slot is free, counting a same-edge pop as freeing one.
module ofm_set_fifo
    import ofm_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  logic       pop_i,
    input  pixel_set_t din_i,
    output pixel_set_t dout_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    pixel_set_t    mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q;

    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign dout_o  = mem_q[rp_q];

    always_ff @(posedge clk)
        if (push_i) mem_q[wp_q] <= din_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wp_q <= wp_q + AW'(1);
            if (pop_i) rp_q <= rp_q + AW'(1);
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

endmodule

// File: rtl/ofm_writeback.sv
// ofm_writeback: captures complete PE output sets, packs them into BRAM words and
// writes them at consecutive addresses from base_addr, one layer pass per start.
module ofm_writeback
    import ofm_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [ADDR_W-1:0]        num_pixels,
    input  logic [NUM_PE-1:0]        valid,
    input  logic [NUM_PE*DATA_W-1:0] ofm_in,
    output logic                     we_OFM,
    output logic [ADDR_W-1:0]        addr_OFM,
    output logic [WORD_W-1:0]        data_out_OFM,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic                     partial_err,
    output logic [ADDR_W-1:0]        pixel_cnt
);

    localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(WORDS_PER_SET - 1);

    wb_state_e         state_q;
    pixel_set_t        cur_q, in_set, fifo_dout;
    logic [WIDX_W-1:0] idx_q;
    logic              have_q, we_q, busy_q, done_q, ovf_q, perr_q;
    logic [ADDR_W-1:0] addr_q, next_addr_q, num_q, cap_q, pix_q;
    logic [WORD_W-1:0] data_q;
    logic              run, all_v, last_word, fifo_full, fifo_empty, pop, push;

    assign in_set    = ofm_in;
    assign run       = state_q == RUN;
    assign all_v     = &valid;
    assign last_word = have_q && idx_q == LAST_IDX;
    // The next set is fetched while the last word of the current one goes out, so a full
    // buffer still accepts a set arriving on that edge.
    assign pop       = run && (!have_q || last_word) && !fifo_empty;
    assign push      = run && all_v && cap_q != num_q && (!fifo_full || pop);

    ofm_set_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (in_set),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            idx_q       <= '0;
            have_q      <= 1'b0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            perr_q      <= 1'b0;
            addr_q      <= '0;
            next_addr_q <= '0;
            num_q       <= '0;
            cap_q       <= '0;
            pix_q       <= '0;
            data_q      <= '0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    num_q       <= num_pixels;
                    next_addr_q <= base_addr;
                    cap_q       <= '0;
                    pix_q       <= '0;
                    ovf_q       <= 1'b0;
                    perr_q      <= 1'b0;
                    state_q     <= num_pixels == '0 ? DONE : RUN;
                    busy_q      <= num_pixels != '0;
                    done_q      <= num_pixels == '0;
                end
                RUN: begin
                    if (pix_q == num_q) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                    if (valid != '0 && !all_v) perr_q <= 1'b1;
                    if (all_v && !push) ovf_q <= 1'b1;
                    if (push) cap_q <= cap_q + ADDR_W'(1);
                    if (have_q || pop) begin
                        we_q        <= 1'b1;
                        addr_q      <= next_addr_q;
                        next_addr_q <= next_addr_q + ADDR_W'(1);
                    end
                    if (have_q) begin
                        data_q <= pack_word(cur_q, idx_q);
                        idx_q  <= last_word ? '0 : idx_q + WIDX_W'(1);
                        if (last_word) begin
                            pix_q  <= pix_q + ADDR_W'(1);
                            have_q <= pop;
                        end
                        if (pop) cur_q <= fifo_dout;
                    end else if (pop) begin
                        data_q <= pack_word(fifo_dout, '0);
                        cur_q  <= fifo_dout;
                        idx_q  <= WIDX_W'(1);
                        have_q <= 1'b1;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign we_OFM       = we_q;
    assign addr_OFM     = addr_q;
    assign data_out_OFM = data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign overflow     = ovf_q;
    assign partial_err  = perr_q;
    assign pixel_cnt    = pix_q;

endmodule

// File: tb/tb_ofm_writeback.sv
// tb_ofm_writeback: scoreboard bench; stimulus queues the expected BRAM writes and a
// negedge monitor pops and compares them as the DUT writes.
module tb_ofm_writeback;

    logic         clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [19:0]  base_addr = '0, num_pixels = '0;
    logic [15:0]  valid = '0;
    logic [127:0] ofm_in = '0;
    logic         we_OFM, busy, done, overflow, partial_err;
    logic [19:0]  addr_OFM, pixel_cnt;
    logic [31:0]  data_out_OFM;

    typedef struct {
        logic [19:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [19:0] mdl_addr = '0;
    int          total = 0, bad = 0, cyc = 0, last_we_cyc = 0, done_cyc = 0, done_cnt = 0;

    ofm_writeback dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .num_pixels   (num_pixels),
        .valid        (valid),
        .ofm_in       (ofm_in),
        .we_OFM       (we_OFM),
        .addr_OFM     (addr_OFM),
        .data_out_OFM (data_out_OFM),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .partial_err  (partial_err),
        .pixel_cnt    (pixel_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] pe_byte(input logic [127:0] s, input int p);
        return s[p*8 +: 8];
    endfunction

    // Reference: set j of a pass lands at base + 4j .. base + 4j + 3, PE 4k first within word k.
    task automatic model_set(input logic [127:0] s);
        for (int k = 0; k < 4; k++) begin
            wr_t e;
            e.a = mdl_addr;
            e.d = {pe_byte(s, 4*k), pe_byte(s, 4*k+1), pe_byte(s, 4*k+2), pe_byte(s, 4*k+3)};
            exp_q.push_back(e);
            mdl_addr = mdl_addr + 20'd1;
        end
    endtask

    always @(negedge clk) begin
        if (we_OFM) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", addr_OFM, data_out_OFM);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_addr", addr_OFM, e.a);
                chk("write_data", data_out_OFM, e.d);
            end
            last_we_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_pass(input logic [19:0] b, input logic [19:0] n);
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = b;
        num_pixels = n;
        mdl_addr = b;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send_set(input logic [127:0] s, input bit acc);
        valid = '1;
        ofm_in = s;
        if (acc) model_set(s);
        tick(1);
        valid = '0;
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while (!done && n < lim) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("done_seen", done, 1);
    endtask

    function automatic logic [127:0] rnd_set();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [127:0] s;
        int d0;

        tick(3);
        chk("rst_we", we_OFM, 0);
        chk("rst_addr", addr_OFM, 0);
        chk("rst_data", data_out_OFM, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_perr", partial_err, 0);
        chk("rst_pcnt", pixel_cnt, 0);
        reset = 1'b0;
        tick(2);

        for (int k = 0; k < 16; k++) s[k*8 +: 8] = 8'(k);
        start_pass(20'h100, 20'd1);
        chk("single_busy", busy, 1);
        send_set(s, 1'b1);
        chk("lat_capture_edge", we_OFM, 0);
        tick(1);
        chk("lat_first_we", we_OFM, 1);
        chk("lat_first_addr", addr_OFM, 20'h100);
        wait_done(50);
        chk("done_after_last", done_cyc, last_we_cyc + 1);
        chk("single_pcnt", pixel_cnt, 1);
        chk("single_ovf", overflow, 0);
        chk("single_perr", partial_err, 0);
        chk("single_busy_end", busy, 0);
        chk("single_all_written", exp_q.size(), 0);
        tick(1);
        chk("done_one_cycle", done, 0);

        d0 = done_cnt;
        start_pass(20'h0, 20'd300);
        for (int j = 0; j < 300; j++) begin
            send_set(rnd_set(), 1'b1);
            tick($urandom_range(3, 10));
        end
        wait_done(200);
        tick(2);
        chk("stream_one_done", done_cnt - d0, 1);
        chk("stream_pcnt", pixel_cnt, 300);
        chk("stream_ovf", overflow, 0);
        chk("stream_all_written", exp_q.size(), 0);

        start_pass(20'h40, 20'd4);
        send_set(rnd_set(), 1'b1);
        send_set(rnd_set(), 1'b1);
        send_set(rnd_set(), 1'b1);
        send_set(rnd_set(), 1'b0);
        send_set(rnd_set(), 1'b1);
        wait_done(100);
        chk("burst_ovf", overflow, 1);
        chk("burst_pcnt", pixel_cnt, 4);
        chk("burst_all_written", exp_q.size(), 0);

        start_pass(20'h500, 20'd1);
        valid = 16'h00FF;
        ofm_in = rnd_set();
        tick(1);
        valid = '0;
        tick(3);
        chk("partial_flag", partial_err, 1);
        chk("partial_pcnt", pixel_cnt, 0);
        chk("partial_busy", busy, 1);
        send_set(rnd_set(), 1'b1);
        wait_done(50);
        chk("partial_then_pcnt", pixel_cnt, 1);
        chk("partial_sticky", partial_err, 1);
        chk("partial_all_written", exp_q.size(), 0);

        start_pass(20'h0, 20'd0);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        tick(1);
        chk("zero_done_drop", done, 0);
        tick(3);

        start_pass(20'hFFFFE, 20'd1);
        send_set(rnd_set(), 1'b1);
        tick(1);
        send_set(rnd_set(), 1'b0);
        wait_done(50);
        chk("wrap_excess_ovf", overflow, 1);
        chk("wrap_pcnt", pixel_cnt, 1);
        chk("wrap_all_written", exp_q.size(), 0);

        start_pass(20'h200, 20'd1);
        send_set(rnd_set(), 1'b1);
        for (int n = 0; n < 20 && !(we_OFM && addr_OFM == 20'h202); n++) @(negedge clk);
        chk("rst_mid_word2_seen", we_OFM && addr_OFM == 20'h202, 1);
        #2 reset = 1'b1;
        #1;
        exp_q.delete();
        chk("rst_mid_we", we_OFM, 0);
        chk("rst_mid_addr", addr_OFM, 0);
        chk("rst_mid_data", data_out_OFM, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_pcnt", pixel_cnt, 0);
        chk("rst_mid_flags", {done, overflow, partial_err}, 0);
        tick(2);
        reset = 1'b0;
        start_pass(20'h300, 20'd1);
        send_set(rnd_set(), 1'b1);
        wait_done(50);
        chk("after_rst_pcnt", pixel_cnt, 1);
        chk("after_rst_all_written", exp_q.size(), 0);

        tick(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ofm_writeback.md
Name: ofm_writeback

Overview:
- Write-side counterpart of the OFM capture interface on Sub_top_CONV.
- Samples the 16 per-PE OFM bytes whenever all 16 valid bits are high, packs them into 32-bit words, and writes them sequentially into the OFM BRAM.
- Sits between the PE array outputs (OFM_0..OFM_15, valid) and the OFM buffer; the layer controller starts it together with cal_start.

Parameters:
NUM_PE, 16, number of PE output channels (multiple of 4)
DATA_W, 8, bits per OFM element
WORD_W, 32, BRAM word width (4 elements)
ADDR_W, 20, OFM BRAM address width
BUF_DEPTH, 2, number of buffered pixel sets (power of 2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; arms a layer pass
base_addr  in  ADDR_W  first OFM word address, sampled on start
num_pixels  in  ADDR_W  pixel sets to write this pass, sampled on start
valid  in  NUM_PE  per-PE output valid
ofm_in  in  NUM_PE*DATA_W  PE k byte at [k*8 +: 8]
we_OFM  out  1  BRAM write enable
addr_OFM  out  ADDR_W  BRAM word address
data_out_OFM  out  WORD_W  BRAM write data
busy  out  1  high from start until done
done  out  1  one-cycle pulse after the last word is written
overflow  out  1  sticky: set arrived while buffer full, or after num_pixels
partial_err  out  1  sticky: valid nonzero but not all ones
pixel_cnt  out  ADDR_W  pixel sets fully written this pass

Behaviour:
- Reset values: all outputs 0; FSM IDLE; buffer empty; counters 0.
- FSM states:
  - IDLE: start leads to RUN (or DONE if num_pixels==0); base_addr and num_pixels are latched; sticky flags clear; busy=1.
  - RUN: capture and write.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- Capture: in RUN, a set is captured on any edge where valid==all ones; ofm_in is pushed into the buffer. valid==0 is ignored. Any other valid value sets partial_err and captures nothing.
- Serializer: pops one set and emits NUM_PE/4 words on consecutive cycles, word k = {PE4k, PE4k+1, PE4k+2, PE4k+3} with PE4k in bits 31:24.
- Addressing:
  - addr_OFM = base + pixel_cnt*(NUM_PE/4) + k, computed with a running counter, not a multiplier.
  - Wraps modulo 2^ADDR_W.
- Latency: all outputs are registered. A set captured at edge N into an empty buffer with the serializer idle produces its first we_OFM during cycle N+1, and words 0..3 during cycles N+1..N+4.
- Back-to-back: a new set can start the cycle after the previous set's last word, giving a sustained rate of 1 set per NUM_PE/4 cycles.
- Buffer full:
  - A set arriving while full sets overflow and is dropped.
  - If the serializer frees a slot on the same edge (last word of the current set), the incoming set is accepted.
- Pixel count: pixel_cnt increments on the last word of each set. When it reaches num_pixels, the FSM goes to DONE on the next edge.
- Excess sets: sets arriving after num_pixels have been captured are dropped and set overflow.
- start outside IDLE is ignored.
- Reset mid-pass: immediate return to IDLE, buffer flushed, we_OFM=0; no partial word is written after reset asserts.
- Outside RUN, we_OFM=0 and valid is ignored.

Decomposition:
- Package ofm_pkg:
  - NUM_PE, DATA_W, WORD_W, ADDR_W.
  - WORDS_PER_SET = NUM_PE*DATA_W/WORD_W.
  - Typedef pixel_set_t (packed NUM_PE x DATA_W).
  - wb_state_e {IDLE, RUN, DONE}.
- Sub-module ofm_set_fifo: BUF_DEPTH-entry FIFO of pixel_set_t with push/pop/full/empty. The top level holds the FSM, serializer, and address/pixel counters.

Test Plan:
- Single set: start, base=0x100, num_pixels=1, PE k byte=k, valid=FFFF for 1 cycle → writes 0x100=00010203, 0x101=04050607, 0x102=08090A0B, 0x103=0C0D0E0F on 4 consecutive cycles; done 1 cycle later; pixel_cnt=1; no flags.
- Steady stream: num_pixels=3136, one valid every 36 cycles with a random byte pattern → 12544 writes at addresses 0..12543, matching the reference model byte for byte; one done pulse; overflow=0.
- Burst stress: valid=FFFF on 4 consecutive cycles with BUF_DEPTH=2 → first 3 sets written (12 words), 4th dropped, overflow=1; and valid on exactly the last-word edge of a full buffer → accepted.
- Partial valid: valid=00FF → partial_err=1, no write, pixel_cnt unchanged; a following FFFF set is written normally.
- Boundaries: num_pixels=0 → done on the cycle after start, no writes; base=0xFFFFE with 1 set → addresses FFFFE, FFFFF, 00000, 00001; a 2nd set after num_pixels=1 → overflow=1.
- Reset mid-pass: assert reset during word 2 of a set → we_OFM=0 from the reset assertion onward, all outputs 0; a fresh start after release writes from base_addr with pixel_cnt=0.
